// File: rtl/stream_add_ctrl_s_axi.sv
// Purpose: AXI4-Lite control slave for the stream-add kernel: ap_ctrl_hs bits, IRQ enable/status, 64-bit scalar n.
// Latency: register write lands the cycle after the W handshake; RVALID one cycle after the AR handshake.
// Backpressure: one outstanding transaction per direction; AW/AR are not re-accepted until BREADY/RREADY retires the previous one.
// Ports: ap_clk/ap_rst (synchronous, active high); s_axi_control_* AXI4-Lite responder; interrupt level to host;
//        ap_start/ap_done/ap_ready/ap_idle kernel handshake; n scalar argument to the kernel core.
module stream_add_ctrl_s_axi #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
    input  logic                    s_axi_control_AWVALID,
    output logic                    s_axi_control_AWREADY,
    input  logic [DATA_WIDTH-1:0]   s_axi_control_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
    input  logic                    s_axi_control_WVALID,
    output logic                    s_axi_control_WREADY,
    output logic [1:0]              s_axi_control_BRESP,
    output logic                    s_axi_control_BVALID,
    input  logic                    s_axi_control_BREADY,
    input  logic [ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
    input  logic                    s_axi_control_ARVALID,
    output logic                    s_axi_control_ARREADY,
    output logic [DATA_WIDTH-1:0]   s_axi_control_RDATA,
    output logic [1:0]              s_axi_control_RRESP,
    output logic                    s_axi_control_RVALID,
    input  logic                    s_axi_control_RREADY,
    output logic                    interrupt,
    output logic                    ap_start,
    input  logic                    ap_done,
    input  logic                    ap_ready,
    input  logic                    ap_idle,
    output logic [63:0]             n
);

    // Word index into the register map; ADDR[1:0] never takes part in decode.
    typedef logic [ADDR_WIDTH-3:0] widx_t;
    localparam widx_t IDX_CTRL = widx_t'(0);
    localparam widx_t IDX_GIE  = widx_t'(1);
    localparam widx_t IDX_IER  = widx_t'(2);
    localparam widx_t IDX_ISR  = widx_t'(3);
    localparam widx_t IDX_NLO  = widx_t'(4);
    localparam widx_t IDX_NHI  = widx_t'(5);

    typedef enum logic [1:0] {WR_RESET, WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_RESET, RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    widx_t                 waddr_q;
    logic                  aw_hs, w_hs, ar_hs;
    logic [DATA_WIDTH-1:0] wmask, rd_mux, rdata_q;
    logic                  start_q, auto_restart, done_q, idle_q, ready_q;
    logic                  gie, irq_q;
    logic [1:0]            ier, isr;
    logic [63:0]           n_q;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

    // ---------------- write channel FSM ----------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) wr_state <= WR_RESET;
        else        wr_state <= wr_next;
    end

    always_comb begin
        wr_next               = wr_state;
        s_axi_control_AWREADY = 1'b0;
        s_axi_control_WREADY  = 1'b0;
        s_axi_control_BVALID  = 1'b0;
        case (wr_state)
            WR_RESET: wr_next = WR_IDLE;
            WR_IDLE: begin
                s_axi_control_AWREADY = 1'b1;
                if (s_axi_control_AWVALID) wr_next = WR_DATA;
            end
            WR_DATA: begin
                s_axi_control_WREADY = 1'b1;
                if (s_axi_control_WVALID) wr_next = WR_RESP;
            end
            WR_RESP: begin
                s_axi_control_BVALID = 1'b1;
                if (s_axi_control_BREADY) wr_next = WR_IDLE;
            end
            default: wr_next = WR_RESET;
        endcase
    end

    assign aw_hs               = s_axi_control_AWVALID & s_axi_control_AWREADY;
    assign w_hs                = s_axi_control_WVALID & s_axi_control_WREADY;
    assign s_axi_control_BRESP = 2'b00;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)     waddr_q <= '0;
        else if (aw_hs) waddr_q <= s_axi_control_AWADDR[ADDR_WIDTH-1:2];
    end

    always_comb begin
        wmask = '0;
        for (int i = 0; i < DATA_WIDTH/8; i++) wmask[8*i +: 8] = {8{s_axi_control_WSTRB[i]}};
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) rd_state <= RD_RESET;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next               = rd_state;
        s_axi_control_ARREADY = 1'b0;
        s_axi_control_RVALID  = 1'b0;
        case (rd_state)
            RD_RESET: rd_next = RD_IDLE;
            RD_IDLE: begin
                s_axi_control_ARREADY = 1'b1;
                if (s_axi_control_ARVALID) rd_next = RD_DATA;
            end
            RD_DATA: begin
                s_axi_control_RVALID = 1'b1;
                if (s_axi_control_RREADY) rd_next = RD_IDLE;
            end
            default: rd_next = RD_RESET;
        endcase
    end

    assign ar_hs               = s_axi_control_ARVALID & s_axi_control_ARREADY;
    assign s_axi_control_RRESP = 2'b00;
    assign s_axi_control_RDATA = rdata_q;

    always_comb begin
        rd_mux = '0;
        case (s_axi_control_ARADDR[ADDR_WIDTH-1:2])
            IDX_CTRL: rd_mux[7:0] = {auto_restart, 3'b000, ready_q, idle_q, done_q, start_q};
            IDX_GIE:  rd_mux[0]   = gie;
            IDX_IER:  rd_mux[1:0] = ier;
            IDX_ISR:  rd_mux[1:0] = isr;
            IDX_NLO:  rd_mux      = n_q[31:0];
            IDX_NHI:  rd_mux      = n_q[63:32];
            default:  rd_mux      = '0;
        endcase
    end

    // ---------------- register file ----------------
    // Later assignments in this block deliberately override earlier ones:
    // kernel events beat clear-on-read and toggle-on-write in the same cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            start_q      <= 1'b0;
            auto_restart <= 1'b0;
            done_q       <= 1'b0;
            idle_q       <= 1'b0;
            ready_q      <= 1'b0;
            gie          <= 1'b0;
            ier          <= 2'b00;
            isr          <= 2'b00;
            irq_q        <= 1'b0;
            n_q          <= '0;
            rdata_q      <= '0;
        end else begin
            idle_q <= ap_idle;
            irq_q  <= gie & (|isr);

            if (ap_ready && !auto_restart) start_q <= 1'b0;
            if (w_hs && waddr_q == IDX_CTRL && s_axi_control_WSTRB[0]) begin
                auto_restart <= s_axi_control_WDATA[7];
                if (s_axi_control_WDATA[0]) start_q <= 1'b1;
            end

            if (ar_hs && s_axi_control_ARADDR[ADDR_WIDTH-1:2] == IDX_CTRL) begin
                done_q  <= 1'b0;
                ready_q <= 1'b0;
            end
            if (ap_done)  done_q  <= 1'b1;
            if (ap_ready) ready_q <= 1'b1;

            if (w_hs && waddr_q == IDX_GIE && s_axi_control_WSTRB[0]) gie <= s_axi_control_WDATA[0];
            if (w_hs && waddr_q == IDX_IER && s_axi_control_WSTRB[0]) ier <= s_axi_control_WDATA[1:0];
            if (w_hs && waddr_q == IDX_ISR && s_axi_control_WSTRB[0]) isr <= isr ^ s_axi_control_WDATA[1:0];
            if (ap_done && ier[0])  isr[0] <= 1'b1;
            if (ap_ready && ier[1]) isr[1] <= 1'b1;

            if (w_hs && waddr_q == IDX_NLO) n_q[31:0]  <= (n_q[31:0] & ~wmask) | (s_axi_control_WDATA & wmask);
            if (w_hs && waddr_q == IDX_NHI) n_q[63:32] <= (n_q[63:32] & ~wmask) | (s_axi_control_WDATA & wmask);

            // Capture the pre-clear value so a clear-on-read still reports the event.
            if (ar_hs) rdata_q <= rd_mux;
        end
    end

    assign ap_start  = start_q;
    assign interrupt = irq_q;
    assign n         = n_q;

endmodule

// File: tb/tb_stream_add_ctrl_s_axi.sv
// Purpose: self-checking bench for stream_add_ctrl_s_axi against a register-map model.
// Latency: model updates on the same edge the DUT commits; outputs compared every negedge.
// Backpressure: bench inserts random BREADY/RREADY stalls and checks valid/data hold.
module tb_stream_add_ctrl_s_axi;

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic        ap_rst;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        interrupt, ap_start;
    logic [63:0] n;

    logic done_dir = 1'b0, rdy_dir = 1'b0, idle_dir = 1'b1;
    logic rk_done = 1'b0, rk_ready = 1'b0, rk_idle = 1'b0;
    logic rand_kernel = 1'b0;
    logic chk_en = 1'b0;
    wire  ap_done  = done_dir | rk_done;
    wire  ap_ready = rdy_dir | rk_ready;
    wire  ap_idle  = idle_dir ^ rk_idle;

    stream_add_ctrl_s_axi #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axi_control_AWADDR(awaddr), .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready),
        .s_axi_control_WDATA(wdata), .s_axi_control_WSTRB(wstrb), .s_axi_control_WVALID(wvalid),
        .s_axi_control_WREADY(wready), .s_axi_control_BRESP(bresp), .s_axi_control_BVALID(bvalid),
        .s_axi_control_BREADY(bready), .s_axi_control_ARADDR(araddr), .s_axi_control_ARVALID(arvalid),
        .s_axi_control_ARREADY(arready), .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
        .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
        .interrupt(interrupt), .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .n(n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural register-map model ----------------
    logic        m_start = 0, m_auto = 0, m_done = 0, m_ready = 0, m_idle = 0, m_gie = 0, m_int = 0;
    logic [1:0]  m_ier = 0, m_isr = 0, old_ier;
    logic [31:0] m_nlo = 0, m_nhi = 0;
    logic        irq_next;
    // Transactions committing at the coming posedge, announced by the driver tasks.
    logic        mw_vld = 0, mr_vld = 0;
    logic [4:0]  mw_addr = 0, mr_addr = 0;
    logic [31:0] mw_data = 0;
    logic [3:0]  mw_strb = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a[4:2])
            3'd0: return {24'd0, m_auto, 3'd0, m_ready, m_idle, m_done, m_start};
            3'd1: return {31'd0, m_gie};
            3'd2: return {30'd0, m_ier};
            3'd3: return {30'd0, m_isr};
            3'd4: return m_nlo;
            3'd5: return m_nhi;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge ap_clk) begin
        if (ap_rst) begin
            m_start = 0; m_auto = 0; m_done = 0; m_ready = 0; m_idle = 0; m_gie = 0; m_int = 0;
            m_ier = 0; m_isr = 0; m_nlo = 0; m_nhi = 0;
        end else begin
            irq_next = m_gie & (m_isr != 2'b00);
            old_ier  = m_ier;
            if (ap_ready && !m_auto) m_start = 0;
            if (mr_vld && mr_addr[4:2] == 3'd0) begin m_done = 0; m_ready = 0; end
            if (ap_done)  m_done  = 1;
            if (ap_ready) m_ready = 1;
            if (mw_vld) begin
                case (mw_addr[4:2])
                    3'd0: if (mw_strb[0]) begin m_auto = mw_data[7]; if (mw_data[0]) m_start = 1; end
                    3'd1: if (mw_strb[0]) m_gie = mw_data[0];
                    3'd2: if (mw_strb[0]) m_ier = mw_data[1:0];
                    3'd3: if (mw_strb[0]) m_isr = m_isr ^ mw_data[1:0];
                    3'd4: m_nlo = merge(m_nlo, mw_data, mw_strb);
                    3'd5: m_nhi = merge(m_nhi, mw_data, mw_strb);
                    default: ;
                endcase
            end
            if (ap_done && old_ier[0])  m_isr[0] = 1;
            if (ap_ready && old_ier[1]) m_isr[1] = 1;
            m_int  = irq_next;
            m_idle = ap_idle;
        end
    end

    // Per-cycle comparison of the kernel-facing outputs.
    always @(negedge ap_clk) begin
        if (chk_en) begin
            chk("ap_start", {63'd0, ap_start}, {63'd0, m_start});
            chk("n", n, {m_nhi, m_nlo});
            chk("interrupt", {63'd0, interrupt}, {63'd0, m_int});
            if (bvalid) chk("bresp", {62'd0, bresp}, 64'd0);
            if (rvalid) chk("rresp", {62'd0, rresp}, 64'd0);
        end
    end

    // Random kernel activity during the random phase.
    always @(negedge ap_clk) begin
        if (rand_kernel) begin
            rk_done  = ($urandom_range(0, 7) == 0);
            rk_ready = ($urandom_range(0, 7) == 0);
            rk_idle  = ($urandom_range(0, 3) == 0);
        end else begin
            rk_done = 0; rk_ready = 0; rk_idle = 0;
        end
    end

    // ---------------- driver tasks (enter and leave at a negedge) ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
        k = 0;
        while (!awready && k < 20) begin @(negedge ap_clk); k++; end
        chk("awready_wait", {63'd0, awready}, 64'd1);
        if (!awready) begin awvalid = 0; wvalid = 0; return; end
        @(negedge ap_clk);
        awvalid = 0;
        chk("wready_after_aw", {63'd0, wready}, 64'd1);
        k = 0;
        while (!wready && k < 20) begin @(negedge ap_clk); k++; end
        if (!wready) begin wvalid = 0; return; end
        mw_vld = 1; mw_addr = a; mw_data = d; mw_strb = s;
        @(negedge ap_clk);
        mw_vld = 0; wvalid = 0;
        chk("bvalid", {63'd0, bvalid}, 64'd1);
        repeat ($urandom_range(0, 2)) begin
            @(negedge ap_clk);
            chk("bvalid_hold", {63'd0, bvalid}, 64'd1);
        end
        bready = 1;
        @(negedge ap_clk);
        bready = 0;
        chk("bvalid_drop", {63'd0, bvalid}, 64'd0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d, input bit pd = 0);
        int k;
        logic [31:0] exp;
        d = 32'd0;
        araddr = a; arvalid = 1;
        k = 0;
        while (!arready && k < 20) begin @(negedge ap_clk); k++; end
        chk("arready_wait", {63'd0, arready}, 64'd1);
        if (!arready) begin arvalid = 0; return; end
        exp = m_read(a);
        mr_vld = 1; mr_addr = a;
        if (pd) done_dir = 1;
        @(negedge ap_clk);
        arvalid = 0; mr_vld = 0; done_dir = 0;
        chk("rvalid_latency", {63'd0, rvalid}, 64'd1);
        chk("rdata", {32'd0, rdata}, {32'd0, exp});
        d = rdata;
        repeat ($urandom_range(0, 2)) begin
            @(negedge ap_clk);
            chk("rvalid_hold", {63'd0, rvalid}, 64'd1);
            chk("rdata_hold", {32'd0, rdata}, {32'd0, exp});
        end
        rready = 1;
        @(negedge ap_clk);
        rready = 0;
        chk("rvalid_drop", {63'd0, rvalid}, 64'd0);
    endtask

    task automatic pulse_done();
        done_dir = 1; @(negedge ap_clk); done_dir = 0;
    endtask

    task automatic pulse_ready();
        rdy_dir = 1; @(negedge ap_clk); rdy_dir = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        int          op;
        logic [4:0]  ra;
        ap_rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;

        @(negedge ap_clk);
        chk_en = 1;
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        @(negedge ap_clk);
        ap_rst = 0;
        @(negedge ap_clk);
        chk("awready_after_rst", {63'd0, awready}, 64'd1);
        chk("arready_after_rst", {63'd0, arready}, 64'd1);
        rd(5'h00, d); chk("ctrl_post_rst", {32'd0, d}, 64'h4);

        // Scalar argument n
        wr(5'h10, 32'd5, 4'hF);
        wr(5'h14, 32'd0, 4'hF);
        chk("n_is_5", n, 64'd5);
        rd(5'h10, d); chk("rd_nlo", {32'd0, d}, 64'd5);
        rd(5'h14, d); chk("rd_nhi", {32'd0, d}, 64'd0);
        wr(5'h14, 32'h0000AB00, 4'b0010);
        chk("n_bytemerge", n, 64'h0000AB00_00000005);
        rd(5'h17, d); chk("rd_nhi_lsb_ignored", {32'd0, d}, 64'h0000AB00);
        wr(5'h1C, 32'hFFFFFFFF, 4'hF);
        rd(5'h18, d); chk("rd_unmapped", {32'd0, d}, 64'd0);

        // ap_start / ap_ready / auto_restart
        wr(5'h00, 32'h1, 4'h1);
        chk("start_set", {63'd0, ap_start}, 64'd1);
        repeat (3) @(negedge ap_clk);
        pulse_ready();
        chk("start_cleared", {63'd0, ap_start}, 64'd0);
        wr(5'h00, 32'h81, 4'h1);
        pulse_ready();
        chk("start_auto_restart", {63'd0, ap_start}, 64'd1);
        wr(5'h00, 32'h0, 4'h1);
        chk("start_write0_noeffect", {63'd0, ap_start}, 64'd1);
        pulse_ready();
        chk("start_cleared2", {63'd0, ap_start}, 64'd0);
        rd(5'h00, d); chk("ctrl_ready_sticky", {32'd0, d}, 64'hC);

        // ap_done clear-on-read, set beats clear
        pulse_done();
        rd(5'h00, d); chk("ctrl_done_set", {32'd0, d}, 64'h6);
        rd(5'h00, d); chk("ctrl_done_cleared", {32'd0, d}, 64'h4);
        rd(5'h00, d, 1); chk("ctrl_done_coincide", {32'd0, d}, 64'h4);
        rd(5'h00, d); chk("ctrl_done_set_wins", {32'd0, d}, 64'h6);

        // Interrupts
        wr(5'h04, 32'h1, 4'h1);
        wr(5'h08, 32'h1, 4'h1);
        pulse_done();
        @(negedge ap_clk);
        chk("irq_raised", {63'd0, interrupt}, 64'd1);
        wr(5'h0C, 32'h1, 4'h1);
        @(negedge ap_clk);
        chk("irq_cleared", {63'd0, interrupt}, 64'd0);
        wr(5'h08, 32'h0, 4'h1);
        pulse_done();
        repeat (2) @(negedge ap_clk);
        chk("irq_masked", {63'd0, interrupt}, 64'd0);
        rd(5'h0C, d); chk("isr_masked", {32'd0, d}, 64'd0);

        // Reset during WR_DATA
        chk("awready_idle", {63'd0, awready}, 64'd1);
        awaddr = 5'h10; wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1; wvalid = 0;
        @(negedge ap_clk);
        awvalid = 0;
        chk("in_wr_data", {63'd0, wready}, 64'd1);
        ap_rst = 1;
        @(negedge ap_clk);
        chk("rst_wr_wready", {63'd0, wready}, 64'd0);
        ap_rst = 0;
        repeat (3) begin
            @(negedge ap_clk);
            chk("rst_wr_no_bvalid", {63'd0, bvalid}, 64'd0);
        end
        rd(5'h10, d); chk("rst_n_zero", {32'd0, d}, 64'd0);
        rd(5'h04, d); chk("rst_gie_zero", {32'd0, d}, 64'd0);
        wr(5'h10, 32'h1234, 4'hF);
        rd(5'h10, d); chk("post_rst_write", {32'd0, d}, 64'h1234);

        // Reset during RD_DATA
        araddr = 5'h10; arvalid = 1;
        @(negedge ap_clk);
        arvalid = 0;
        chk("in_rd_data", {63'd0, rvalid}, 64'd1);
        ap_rst = 1;
        @(negedge ap_clk);
        chk("rst_rd_rdata", {32'd0, rdata}, 64'd0);
        ap_rst = 0;
        repeat (3) begin
            @(negedge ap_clk);
            chk("rst_rd_no_rvalid", {63'd0, rvalid}, 64'd0);
        end
        rd(5'h10, d); chk("post_rst_read", {32'd0, d}, 64'd0);

        // Random phase
        rand_kernel = 1;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            ra = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if (op < 4)      wr(ra, $urandom, 4'($urandom_range(0, 15)));
            else if (op < 8) rd(ra, d);
            else             repeat ($urandom_range(1, 3)) @(negedge ap_clk);
        end
        rand_kernel = 0;
        repeat (3) @(negedge ap_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
